// File: rtl/parity_frame_tx.sv
// ============================================================================
// Module      : parity_frame_tx
// Description : Serial transmitter sending START, N data bits LSB-first,
//               a parity bit and STOP, each CLKS_PER_BIT clocks long.
//               Define PARITY_FRAME_TX_ODD_EN for odd parity (default even).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_frame_tx #(
  parameter int N            = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic         tx_out,
  output logic         busy,
  output logic         done
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT) + 1;
  localparam int c_idx_w = $clog2(N) + 1;

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_next;
  logic [c_idx_w-1:0] r_idx;
  logic [c_idx_w-1:0] w_idx_next;
  logic [N-1:0]       r_data;
  logic               r_par;
  logic               r_tx;
  logic               r_done;
  logic               w_ready;
  logic               w_accept;
  logic               w_bit_end;
  logic               w_par_in;
  logic               w_data_bit;
  logic               w_tx_next;

  assign w_ready   = (r_state == c_st_idle) && !rst;
  assign w_accept  = valid_in && w_ready;
  assign w_bit_end = (r_cnt == c_cnt_last);

`ifdef PARITY_FRAME_TX_ODD_EN
  assign w_par_in = ~(^data_in);
`else
  assign w_par_in = ^data_in;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, bit-period counter and bit-index logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + c_cnt_w'(1);
    w_idx_next   = r_idx;
    if (w_bit_end) begin
      w_cnt_next = '0;
    end
    case (r_state)
      c_st_idle: begin
        w_cnt_next = '0;
        w_idx_next = '0;
        if (w_accept) begin
          w_state_next = c_st_start;
        end
      end
      c_st_start: begin
        if (w_bit_end) begin
          w_state_next = c_st_data;
          w_idx_next   = '0;
        end
      end
      c_st_data: begin
        if (w_bit_end) begin
          if (r_idx == c_idx_last) begin
            w_state_next = c_st_parity;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + c_idx_w'(1);
          end
        end
      end
      c_st_parity: begin
        if (w_bit_end) begin
          w_state_next = c_st_stop;
        end
      end
      c_st_stop: begin
        if (w_bit_end) begin
          w_state_next = c_st_idle;
        end
      end
      default: begin
        w_state_next = c_st_idle;
        w_cnt_next   = '0;
        w_idx_next   = '0;
      end
    endcase
  end

  // Outputs; tx is precomputed from the next state so the register shows
  // the start bit right after the accepting edge.
  always_comb begin
    ready_out  = w_ready;
    busy       = (r_state != c_st_idle);
    done       = r_done;
    tx_out     = r_tx;
    w_data_bit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_idx_next == c_idx_w'(i)) begin
        w_data_bit = r_data[i];
      end
    end
    case (w_state_next)
      c_st_start:  w_tx_next = 1'b0;
      c_st_data:   w_tx_next = w_data_bit;
      c_st_parity: w_tx_next = r_par;
      default:     w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_data <= '0;
      r_par  <= 1'b0;
      r_tx   <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_idx  <= w_idx_next;
      r_tx   <= w_tx_next;
      r_done <= (r_state == c_st_stop) && w_bit_end;
      if (w_accept) begin
        r_data <= data_in;
        r_par  <= w_par_in;
      end
    end
  end

endmodule

`default_nettype wire
